// File: rtl/tlp_loopback_if.sv
// Request/response TLP buffer interface between the RX/TX FIFOs and the loopback responder.
// Handshake: a request transfers on a clock edge where i_rx_valid & o_rx_rd; a response transfers on an edge where i_tx_rdy & o_tx_wr.
interface tlp_loopback_if #(
  parameter int unsigned TLP_RX_WIDTH = 56,
  parameter int unsigned TLP_TX_WIDTH = 34
);
  logic [TLP_RX_WIDTH-1:0] i_rx_tlp;
  logic                    i_rx_valid;
  logic                    o_rx_rd;
  logic [TLP_TX_WIDTH-1:0] o_tx_tlp;
  logic                    i_tx_rdy;
  logic                    o_tx_wr;

  modport slave (
    input  i_rx_tlp, i_rx_valid, i_tx_rdy,
    output o_rx_rd, o_tx_tlp, o_tx_wr
  );

  modport master (
    output i_rx_tlp, i_rx_valid, i_tx_rdy,
    input  o_rx_rd, o_tx_tlp, o_tx_wr
  );
endinterface

// File: rtl/tlp_loopback_responder.sv
// Pops one request TLP, executes its opcode, and pushes one response TLP.
// Responses that wait too long on a full TX buffer are dropped and counted.
module tlp_loopback_responder #(
  parameter int unsigned TLP_RX_WIDTH   = 56,
  parameter int unsigned TLP_TX_WIDTH   = 34,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_enable,
  tlp_loopback_if.slave bus,
  input  logic        i_err_clr,
  output logic [31:0] o_req_cnt,
  output logic [15:0] o_drop_cnt,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [TLP_RX_WIDTH-1:0] req_q;
  logic [TLP_TX_WIDTH-1:0] rsp_q, rsp_d;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    rx_rd, tx_wr, timeout_hit, bad_op;
  logic [7:0]              op;
  logic [15:0]             arg;
  logic [31:0]             d;
  logic [32:0]             sum;

  assign op  = req_q[55:48];
  assign arg = req_q[47:32];
  assign d   = req_q[31:0];

  // The last permitted wait cycle with rdy still low ends the attempt.
  assign timeout_hit = (state_q == WRITE) && !bus.i_tx_rdy &&
                       (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable && bus.i_rx_valid) state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   if (bus.i_tx_rdy || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_rd  = (state_q == IDLE) && i_enable && bus.i_rx_valid;
    tx_wr  = (state_q == WRITE) && bus.i_tx_rdy;
    o_busy = (state_q != IDLE);
  end

  assign bus.o_rx_rd  = rx_rd;
  assign bus.o_tx_wr  = tx_wr;
  assign bus.o_tx_tlp = rsp_q;
  assign o_state      = state_q;

  always_comb begin
    sum    = {1'b0, d} + {17'h0, arg};
    bad_op = 1'b0;
    case (op)
      8'h01:   rsp_d = {2'b00, d};
      8'h02:   rsp_d = {2'b00, ~d};
      8'h03:   rsp_d = {1'b0, sum};
      8'h04:   rsp_d = {2'b00, o_req_cnt};
      default: begin
        rsp_d  = {2'b11, 24'h0, op};
        bad_op = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      req_q      <= '0;
      rsp_q      <= '0;
      wait_cnt   <= '0;
      o_req_cnt  <= '0;
      o_drop_cnt <= '0;
      o_err      <= 1'b0;
    end else begin
      if (rx_rd) req_q <= bus.i_rx_tlp;
      if (state_q == EXEC) begin
        rsp_q     <= rsp_d;
        o_req_cnt <= o_req_cnt + 32'd1;
      end
      // A new unknown opcode outranks a simultaneous clear.
      if ((state_q == EXEC) && bad_op) o_err <= 1'b1;
      else if (i_err_clr)              o_err <= 1'b0;
      if (state_q != WRITE)     wait_cnt <= '0;
      else if (!bus.i_tx_rdy)   wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tlp_loopback_responder.sv
// Bench for tlp_loopback_responder: transaction-level reference model with per-cycle compare,
// directed literal scenarios, then randomized traffic.
module tb_tlp_loopback_responder;

  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic        i_enable;
  logic        i_err_clr;
  logic [31:0] o_req_cnt;
  logic [15:0] o_drop_cnt;
  logic        o_busy;
  logic        o_err;
  logic [1:0]  o_state;

  tlp_loopback_if bus();

  tlp_loopback_responder #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_enable(i_enable), .bus(bus),
    .i_err_clr(i_err_clr), .o_req_cnt(o_req_cnt), .o_drop_cnt(o_drop_cnt),
    .o_busy(o_busy), .o_err(o_err), .o_state(o_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int          n_vec = 0, n_miss = 0;
  logic [55:0] rx_fifo[$];
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  int          obs_cyc_q[$];
  int          cyc = 0, n_pop = 0, n_push = 0, last_pop_cyc = 0;

  // reference model state
  bit          m_have = 0;
  int          m_pop_cyc = 0;
  logic [55:0] m_req = '0;
  logic [33:0] m_rsp = '0;
  logic [31:0] m_cnt = '0;
  logic [15:0] m_drop = '0;
  logic        m_err = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [33:0] spec_rsp(logic [55:0] r, logic [31:0] cnt);
    logic [7:0]  op;
    logic [15:0] arg;
    logic [31:0] d;
    logic [32:0] s;
    op = r[55:48]; arg = r[47:32]; d = r[31:0];
    case (op)
      8'h01: return {2'b00, d};
      8'h02: return {2'b00, ~d};
      8'h03: begin s = {1'b0, d} + {17'h0, arg}; return {1'b0, s}; end
      8'h04: return {2'b00, cnt};
      default: return {2'b11, 24'h0, op};
    endcase
  endfunction

  function automatic logic [33:0] obs_at(int i);
    if (i < obs_q.size()) return obs_q[i];
    return 'x;
  endfunction

  function automatic int obs_cyc_at(int i);
    if (i < obs_cyc_q.size()) return obs_cyc_q[i];
    return -1000;
  endfunction

  // compare process: every cycle, away from the active edge
  always @(negedge i_clk) begin
    int  age;
    bit  exp_rd, exp_wr, set_err;
    if (i_arst) begin
      check("rst_busy", o_busy, 0);
      check("rst_tx_wr", bus.o_tx_wr, 0);
      check("rst_tx_tlp", bus.o_tx_tlp, 0);
      check("rst_req_cnt", o_req_cnt, 0);
      check("rst_drop_cnt", o_drop_cnt, 0);
      check("rst_err", o_err, 0);
      m_have = 0; m_cnt = '0; m_drop = '0; m_err = 1'b0; m_rsp = '0;
    end else begin
      age    = cyc - m_pop_cyc;
      exp_rd = !m_have && i_enable && bus.i_rx_valid;
      exp_wr = m_have && (age >= 2) && bus.i_tx_rdy;
      check("busy", o_busy, m_have);
      check("rx_rd", bus.o_rx_rd, exp_rd);
      check("tx_wr", bus.o_tx_wr, exp_wr);
      check("req_cnt", o_req_cnt, m_cnt);
      check("drop_cnt", o_drop_cnt, m_drop);
      check("err", o_err, m_err);
      if (bus.o_tx_wr && exp_wr) check("tx_tlp", bus.o_tx_tlp, m_rsp);
      if (bus.o_tx_wr) begin
        obs_q.push_back(bus.o_tx_tlp);
        obs_cyc_q.push_back(cyc);
        n_push++;
      end
      if (bus.o_rx_rd && rx_fifo.size() != 0) begin
        void'(rx_fifo.pop_front());
        last_pop_cyc = cyc;
        n_pop++;
      end
      set_err = 1'b0;
      if (m_have && age == 1) begin
        m_rsp   = spec_rsp(m_req, m_cnt);
        m_cnt   = m_cnt + 32'd1;
        set_err = (m_rsp[33:32] == 2'b11);
      end
      if (set_err) m_err = 1'b1;
      else if (i_err_clr) m_err = 1'b0;
      if (m_have && age >= 2) begin
        if (bus.i_tx_rdy) m_have = 0;
        else if (age - 1 == T) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          m_have = 0;
        end
      end
      if (exp_rd) begin
        m_have = 1; m_pop_cyc = cyc; m_req = bus.i_rx_tlp;
      end
    end
    cyc++;
  end

  // driver tasks
  task automatic present();
    bus.i_rx_valid = (rx_fifo.size() != 0);
    bus.i_rx_tlp   = (rx_fifo.size() != 0) ? rx_fifo[0] : 56'h0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    present();
  endtask

  task automatic send(logic [55:0] r);
    rx_fifo.push_back(r);
    present();
  endtask

  task automatic wait_pop(int target, int bound, string name);
    int k = 0;
    while (n_pop < target && k < bound) begin tick(); k++; end
    check(name, n_pop >= target, 1);
  endtask

  task automatic wait_push(int target, int bound, string name);
    int k = 0;
    while (n_push < target && k < bound) begin tick(); k++; end
    check(name, n_push >= target, 1);
  endtask

  task automatic do_reset();
    i_enable = 1'b0; i_err_clr = 1'b0; bus.i_tx_rdy = 1'b0;
    rx_fifo.delete();
    present();
    i_arst = 1'b1;
    repeat (2) tick();
    i_arst = 1'b0;
    obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    n_push = 0; n_pop = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes_before;
    logic [55:0] r;
    i_arst = 1'b1; i_enable = 1'b0; i_err_clr = 1'b0; bus.i_tx_rdy = 1'b0;
    present();
    do_reset();
    check("reset_state", o_state, 0);
    check("reset_req_cnt", o_req_cnt, 0);

    // ECHO, ADD carry, INV
    i_enable = 1'b1; bus.i_tx_rdy = 1'b1;
    send(56'h01_0000_DEADBEEF);
    wait_push(1, 10, "echo_push");
    check("echo_tlp", obs_at(0), 34'h0_DEADBEEF);
    check("echo_latency", obs_cyc_at(0) - last_pop_cyc, 2);
    check("echo_pops", n_pop, 1);
    send(56'h03_0002_FFFFFFFF);
    wait_push(2, 10, "add_push");
    check("add_carry_tlp", obs_at(1), 34'h1_00000001);
    send(56'h02_0000_00000000);
    wait_push(3, 10, "inv_push");
    check("inv_tlp", obs_at(2), 34'h0_FFFFFFFF);

    // back-to-back, then COUNT
    do_reset();
    i_enable = 1'b1; bus.i_tx_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({2'b00, 32'h1000_0000 + 32'(i)});
      send({8'h01, 16'h0, 32'h1000_0000 + 32'(i)});
    end
    wait_push(5, 40, "b2b_push");
    for (int i = 0; i < 5; i++) check("b2b_tlp", obs_at(i), exp_q[i]);
    for (int i = 1; i < 5; i++) check("b2b_spacing", obs_cyc_at(i) - obs_cyc_at(i - 1), 3);
    send(56'h04_0000_00000000);
    wait_push(6, 10, "count_push");
    check("count_tlp", obs_at(5), 34'h0_00000005);
    tick();
    check("count_req_cnt", o_req_cnt, 6);

    // timeout drop
    do_reset();
    i_enable = 1'b1;
    send(56'h01_0000_12345678);
    wait_pop(1, 10, "to_pop");
    repeat (8) tick();
    check("to_no_push", n_push, 0);
    check("to_drop_cnt", o_drop_cnt, 1);
    check("to_idle", o_busy, 0);

    // rdy rises on the third wait cycle
    do_reset();
    i_enable = 1'b1;
    send(56'h01_0000_CAFEF00D);
    wait_pop(1, 10, "late_pop");
    repeat (3) tick();
    bus.i_tx_rdy = 1'b1;
    wait_push(1, 10, "late_push");
    check("late_tlp", obs_at(0), 34'h0_CAFEF00D);
    check("late_drop_cnt", o_drop_cnt, 0);

    // unknown opcode, set-wins-over-clear, then clear
    send(56'h7F_0000_00000000);
    wait_push(2, 10, "bad_push");
    check("bad_tlp", obs_at(1), 34'h3_0000007F);
    tick();
    check("bad_err", o_err, 1);
    pushes_before = n_pop;
    send(56'h55_1234_00000000);
    wait_pop(pushes_before + 1, 10, "bad2_pop");
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check("err_set_wins", o_err, 1);
    wait_push(3, 10, "bad2_push");
    check("bad2_tlp", obs_at(2), 34'h3_00000055);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    tick();
    check("err_cleared", o_err, 0);

    // reset while in WRITE
    bus.i_tx_rdy = 1'b0;
    pushes_before = n_pop;
    send(56'h01_0000_0BADF00D);
    wait_pop(pushes_before + 1, 10, "rw_pop");
    tick();
    check("rw_in_write", o_busy, 1);
    #2;
    i_arst = 1'b1;
    #1;
    check("rw_busy", o_busy, 0);
    check("rw_tx_wr", bus.o_tx_wr, 0);
    check("rw_req_cnt", o_req_cnt, 0);
    check("rw_drop_cnt", o_drop_cnt, 0);
    repeat (2) tick();
    i_arst = 1'b0;
    bus.i_tx_rdy = 1'b1;
    pushes_before = n_push;
    repeat (10) tick();
    check("rw_no_push", n_push - pushes_before, 0);
    check("rw_idle", o_busy, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick();
      i_enable     = ($urandom_range(0, 9) != 0);
      bus.i_tx_rdy = ($urandom_range(0, 99) < 55);
      i_err_clr    = ($urandom_range(0, 19) == 0);
      if (rx_fifo.size() < 4 && $urandom_range(0, 9) < 4) begin
        r = {8'h00, 16'($urandom), 32'($urandom)};
        case ($urandom_range(0, 9))
          0, 1:    r[55:48] = 8'h01;
          2, 3:    r[55:48] = 8'h02;
          4, 5:    r[55:48] = 8'h03;
          6, 7:    r[55:48] = 8'h04;
          default: r[55:48] = 8'($urandom);
        endcase
        send(r);
      end
    end
    i_enable = 1'b0;
    bus.i_tx_rdy = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
